// File: rtl/regfile_pkg.sv
// regfile_pkg: widths, entry type and pointer helper shared by the writeback queue and the register file.
package regfile_pkg;
    localparam int IDX_W    = 2;
    localparam int DATA_W   = 4;
    localparam int WB_DEPTH = 8;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned k,
                                             input int unsigned depth);
        return (ptr + k) % depth;
    endfunction
endpackage

// File: rtl/wb_dual_port_fifo.sv
// wb_dual_port_fifo: 2-in/2-out circular buffer; caller supplies enqueue/dequeue counts and
// guarantees they never overflow or underflow the occupancy.
module wb_dual_port_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 wr_n_i,
    input  wb_entry_t                  wr_0_i,
    input  wb_entry_t                  wr_1_i,
    input  logic [1:0]                 rd_n_i,
    output wb_entry_t                  head_0_o,
    output wb_entry_t                  head_1_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, head_1, tail_1;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        head_1   = PTR_W'(ptr_wrap(32'(head_q), 1, DEPTH));
        tail_1   = PTR_W'(ptr_wrap(32'(tail_q), 1, DEPTH));
        head_d   = PTR_W'(ptr_wrap(32'(head_q), 32'(rd_n_i), DEPTH));
        tail_d   = PTR_W'(ptr_wrap(32'(tail_q), 32'(wr_n_i), DEPTH));
        count_d  = count_q + CNT_W'(wr_n_i) - CNT_W'(rd_n_i);
        head_0_o = mem_q[head_q];
        head_1_o = mem_q[head_1];
        count_o  = count_q;
    end

    // Storage is deliberately left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_n_i != 2'd0) mem_q[tail_q] <= wr_0_i;
        if (wr_n_i == 2'd2) mem_q[tail_1] <= wr_1_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: writeback staging queue feeding the register file's two write ports,
// splitting same-index pairs so the ports never collide.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       io_in_0_valid,
    input  logic [IDX_W-1:0]           io_in_0_idx,
    input  logic [DATA_W-1:0]          io_in_0_data,
    input  logic                       io_in_1_valid,
    input  logic [IDX_W-1:0]           io_in_1_idx,
    input  logic [DATA_W-1:0]          io_in_1_data,
    output logic                       io_in_ready,
    input  logic                       io_hold,
    output logic                       io_wp_0_en,
    output logic [IDX_W-1:0]           io_wp_0_idx,
    output logic [DATA_W-1:0]          io_wp_0_data,
    output logic                       io_wp_1_en,
    output logic [IDX_W-1:0]           io_wp_1_idx,
    output logic [DATA_W-1:0]          io_wp_1_data,
    output logic [$clog2(DEPTH+1)-1:0] io_count,
    output logic                       io_empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t  lane_0, lane_1, wr_0, head_0, head_1;
    logic       acc_0, acc_1;
    logic [1:0] wr_n, rd_n;

    // Ready looks only at registered count, so no path from hold/drain reaches it.
    always_comb begin
        lane_0       = '{idx: io_in_0_idx, data: io_in_0_data};
        lane_1       = '{idx: io_in_1_idx, data: io_in_1_data};
        io_in_ready  = io_count <= CNT_W'(DEPTH - 2);
        acc_0        = io_in_0_valid && io_in_ready;
        acc_1        = io_in_1_valid && io_in_ready;
        wr_n         = {1'b0, acc_0} + {1'b0, acc_1};
        wr_0         = acc_0 ? lane_0 : lane_1;
        io_wp_0_en   = (io_count != '0) && !io_hold;
        io_wp_1_en   = (io_count >= CNT_W'(2)) && !io_hold && (head_0.idx != head_1.idx);
        rd_n         = {1'b0, io_wp_0_en} + {1'b0, io_wp_1_en};
        io_wp_0_idx  = head_0.idx;
        io_wp_0_data = head_0.data;
        io_wp_1_idx  = head_1.idx;
        io_wp_1_data = head_1.data;
        io_empty     = io_count == '0;
    end

    wb_dual_port_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .wr_n_i   (wr_n),
        .wr_0_i   (wr_0),
        .wr_1_i   (lane_1),
        .rd_n_i   (rd_n),
        .head_0_o (head_0),
        .head_1_o (head_1),
        .count_o  (io_count)
    );
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: scoreboard bench; accepted writes are queued in order and matched
// against the write ports, with a register-file shadow for end values.
module tb_regfile_wb_queue;
    import regfile_pkg::*;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_0_valid = 1'b0, in_1_valid = 1'b0, hold = 1'b0;
    logic [IDX_W-1:0]  in_0_idx = '0, in_1_idx = '0;
    logic [DATA_W-1:0] in_0_data = '0, in_1_data = '0;
    logic              in_ready, empty, wp_0_en, wp_1_en;
    logic [IDX_W-1:0]  wp_0_idx, wp_1_idx;
    logic [DATA_W-1:0] wp_0_data, wp_1_data;
    logic [3:0]        count;

    wb_entry_t         sb [$];
    logic [DATA_W-1:0] rf_act [1 << IDX_W];
    int                n_vec = 0, n_err = 0;

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_in_0_valid (in_0_valid),
        .io_in_0_idx   (in_0_idx),
        .io_in_0_data  (in_0_data),
        .io_in_1_valid (in_1_valid),
        .io_in_1_idx   (in_1_idx),
        .io_in_1_data  (in_1_data),
        .io_in_ready   (in_ready),
        .io_hold       (hold),
        .io_wp_0_en    (wp_0_en),
        .io_wp_0_idx   (wp_0_idx),
        .io_wp_0_data  (wp_0_data),
        .io_wp_1_en    (wp_1_en),
        .io_wp_1_idx   (wp_1_idx),
        .io_wp_1_data  (wp_1_data),
        .io_count      (count),
        .io_empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model step: outputs are checked mid-cycle against the queue, then pops/pushes for the next edge.
    always @(negedge clk) begin
        int  n;
        bit  e0, e1;
        if (!reset) begin
            check("rst_count", count, 0);
            check("rst_wp0_en", wp_0_en, 0);
            check("rst_wp1_en", wp_1_en, 0);
            check("rst_ready", in_ready, 1);
            sb.delete();
        end else begin
            n  = sb.size();
            e0 = n >= 1 && !hold;
            e1 = n >= 2 && !hold && sb[0].idx != sb[1].idx;
            check("count", count, n);
            check("ready", in_ready, int'(n <= DEPTH - 2));
            check("empty", empty, int'(n == 0));
            check("wp0_en", wp_0_en, e0);
            check("wp1_en", wp_1_en, e1);
            if (n >= 1) begin
                check("wp0_idx", wp_0_idx, sb[0].idx);
                check("wp0_data", wp_0_data, sb[0].data);
            end
            if (n >= 2) begin
                check("wp1_idx", wp_1_idx, sb[1].idx);
                check("wp1_data", wp_1_data, sb[1].data);
            end
            if (wp_0_en) rf_act[wp_0_idx] = wp_0_data;
            if (wp_1_en) rf_act[wp_1_idx] = wp_1_data;
            if (e0) void'(sb.pop_front());
            if (e1) void'(sb.pop_front());
            if (n <= DEPTH - 2) begin
                if (in_0_valid) sb.push_back('{idx: in_0_idx, data: in_0_data});
                if (in_1_valid) sb.push_back('{idx: in_1_idx, data: in_1_data});
            end
        end
    end

    task automatic drive(input bit v0, input int i0, input int d0,
                         input bit v1, input int i1, input int d1, input bit h);
        @(posedge clk);
        #2;
        in_0_valid = v0;
        in_0_idx   = IDX_W'(i0);
        in_0_data  = DATA_W'(d0);
        in_1_valid = v1;
        in_1_idx   = IDX_W'(i1);
        in_1_data  = DATA_W'(d1);
        hold       = h;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << IDX_W); i++) rf_act[i] = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        idle(10);

        drive(1, 1, 'hA, 1, 2, 'h5, 0);
        idle(3);
        check("rf1", rf_act[1], 'hA);
        check("rf2", rf_act[2], 'h5);

        drive(1, 3, 'h1, 1, 3, 'h2, 0);
        idle(4);
        check("rf3_order", rf_act[3], 'h2);

        drive(1, 0, 'h1, 1, 1, 'h2, 1);
        drive(1, 2, 'h3, 1, 3, 'h4, 1);
        drive(1, 0, 'h5, 1, 1, 'h6, 1);
        drive(0, 0, 0, 1, 2, 'h7, 1);
        check("fill_count6", count, 6);
        check("fill_ready6", in_ready, 1);
        drive(1, 3, 'h8, 1, 0, 'h9, 1);
        check("fill_count7", count, 7);
        check("fill_ready7", in_ready, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("drop_count7", count, 7);
        idle(6);
        check("drain_empty", empty, 1);

        drive(1, 1, 'hB, 1, 2, 'hC, 1);
        drive(1, 3, 'hD, 1, 0, 'hE, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("simul_count2", count, 2);
        idle(3);
        check("simul_rf3", rf_act[3], 'hD);
        check("simul_rf0", rf_act[0], 'hE);

        drive(1, 1, 'h1, 1, 2, 'h2, 1);
        drive(1, 3, 'h3, 1, 1, 'h4, 1);
        drive(1, 2, 'h5, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("pre_rst_count5", count, 5);
        #1 hold = 1'b0;
        reset = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_wp0_en", wp_0_en, 0);
        check("async_wp1_en", wp_1_en, 0);
        check("async_empty", empty, 1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        drive(1, 0, 'hF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_wp0_idx", wp_0_idx, 0);
        check("post_rst_wp0_data", wp_0_data, 'hF);
        check("post_rst_wp0_en", wp_0_en, 1);
        check("post_rst_wp1_en", wp_1_en, 0);
        idle(3);
        check("post_rst_rf0", rf_act[0], 'hF);
        check("final_sb", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
